lcd_spi_rx: RTL and testbench

- SPI-slave receiver and decoder for the 4-wire LCD write stream: SCLK, MOSI, CS and the DC line (0 = command, 1 = data).
- This is the panel end of the link that the LCD driver transmits on.
- Rebuilds bytes, decodes the window and memory-write commands (CASET 0x2A, RASET 0x2B, RAMWR 0x2C), and emits RGB565 pixel writes with x/y coordinates.
- Used as an in-fabric display model and as a stream checker on the LCD bus.

---
 rtl/lcd_pkg.sv | 18 +
 rtl/lcd_spi_rx_if.sv | 34 +++
 rtl/lcd_spi_byte_rx.sv | 86 ++++++++
 rtl/lcd_spi_rx.sv | 151 +++++++++++++++
 tb/tb_lcd_spi_rx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared constants and types for the LCD SPI receive path.
package lcd_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  localparam int RGB565_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_P,
    ST_RASET_P,
    ST_RAMWR,
    ST_SKIP
  } lcd_state_e;

endpackage

// File: rtl/lcd_spi_rx_if.sv
// LCD write bus (4-wire SPI in) and decoded command/pixel stream (out).
interface lcd_spi_rx_if
  import lcd_pkg::*;
#(
  parameter int H_RES = 240,
  parameter int V_RES = 240
);
  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);

  logic                spi_sclk;
  logic                spi_mosi;
  logic                spi_cs;
  logic                spi_dc;
  logic                cmd_valid;
  logic [7:0]          cmd_byte;
  logic                pix_valid;
  logic [XW-1:0]       pix_x;
  logic [YW-1:0]       pix_y;
  logic [RGB565_W-1:0] pix_data;
  logic                frame_done;
  logic                err;

  modport master (
    output spi_sclk, spi_mosi, spi_cs, spi_dc,
    input  cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data, frame_done, err
  );

  modport slave (
    input  spi_sclk, spi_mosi, spi_cs, spi_dc,
    output cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data, frame_done, err
  );

endinterface

// File: rtl/lcd_spi_byte_rx.sv
// SPI mode-0 byte deserialiser: synchronises the pins, shifts MSB first and
// strobes each completed byte with its DC tag.
module lcd_spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_i,
  input  logic       dc_i,
  output logic [7:0] byte_o,
  output logic       dc_o,
  output logic       strobe_o,
  output logic       abort_o
);

  logic [3:0]                  pins;
  logic [3:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic                        sclk_s, mosi_s, cs_s, dc_s;
  logic                        sclk_prev_q, sclk_prev_d;
  logic [7:0]                  shift_q, shift_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic [7:0]                  byte_q, byte_d;
  logic                        dc_q, dc_d;
  logic                        strobe_q, strobe_d;
  logic                        abort_q, abort_d;

  assign pins   = {dc_i, cs_i, mosi_i, sclk_i};
  assign sclk_s = sync_q[0][SYNC_STAGES-1];
  assign mosi_s = sync_q[1][SYNC_STAGES-1];
  assign cs_s   = sync_q[2][SYNC_STAGES-1];
  assign dc_s   = sync_q[3][SYNC_STAGES-1];

  always_comb begin
    for (int i = 0; i < 4; i++) sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], pins[i]};
    sclk_prev_d = sclk_s;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    dc_d        = dc_q;
    strobe_d    = 1'b0;
    abort_d     = 1'b0;
    if (cs_s) begin
      // deselect drops any partial byte; only a nonzero count is an error
      cnt_d   = 3'd0;
      abort_d = (cnt_q != 3'd0);
    end else if (sclk_s && !sclk_prev_q) begin
      shift_d = {shift_q[6:0], mosi_s};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        strobe_d = 1'b1;
        byte_d   = {shift_q[6:0], mosi_s};
        dc_d     = dc_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sclk_prev_q <= 1'b0;
      shift_q     <= '0;
      cnt_q       <= '0;
      byte_q      <= '0;
      dc_q        <= 1'b0;
      strobe_q    <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_prev_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      dc_q        <= dc_d;
      strobe_q    <= strobe_d;
      abort_q     <= abort_d;
    end
  end

  assign byte_o   = byte_q;
  assign dc_o     = dc_q;
  assign strobe_o = strobe_q;
  assign abort_o  = abort_q;

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD write-stream decoder: window commands and RAMWR pixel cursor on top of
// the SPI byte receiver.
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter int H_RES       = 240,
  parameter int V_RES       = 240,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst_n,
  lcd_spi_rx_if.slave bus
);

  localparam int XW = $clog2(H_RES);
  localparam int YW = $clog2(V_RES);
  localparam logic [15:0] H_LIM = 16'(H_RES);
  localparam logic [15:0] V_LIM = 16'(V_RES);

  logic [7:0] rx_byte;
  logic       rx_dc, rx_strobe, rx_abort;

  lcd_spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk_i   (bus.spi_sclk),
    .mosi_i   (bus.spi_mosi),
    .cs_i     (bus.spi_cs),
    .dc_i     (bus.spi_dc),
    .byte_o   (rx_byte),
    .dc_o     (rx_dc),
    .strobe_o (rx_strobe),
    .abort_o  (rx_abort)
  );

  lcd_state_e          state_q;
  logic [1:0]          pcnt_q;
  logic [23:0]         par_q;
  logic [XW-1:0]       xs_q, xe_q, cx_q;
  logic [YW-1:0]       ys_q, ye_q, cy_q;
  logic                phase_lo_q;
  logic [7:0]          hi_q;
  logic                cmd_valid_q, pix_valid_q, frame_done_q, err_q;
  logic [7:0]          cmd_byte_q;
  logic [XW-1:0]       pix_x_q;
  logic [YW-1:0]       pix_y_q;
  logic [RGB565_W-1:0] pix_data_q;
  logic [15:0]         p_start, p_end;
  logic                x_ok, y_ok;

  // the fourth parameter byte completes the end coordinate on the fly
  assign p_start = par_q[23:8];
  assign p_end   = {par_q[7:0], rx_byte};
  assign x_ok    = (p_start <= p_end) && (p_end < H_LIM);
  assign y_ok    = (p_start <= p_end) && (p_end < V_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pcnt_q       <= '0;
      par_q        <= '0;
      xs_q         <= '0;
      xe_q         <= XW'(H_RES - 1);
      ys_q         <= '0;
      ye_q         <= YW'(V_RES - 1);
      cx_q         <= '0;
      cy_q         <= '0;
      phase_lo_q   <= 1'b0;
      hi_q         <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cmd_valid_q  <= 1'b0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= rx_abort;
      if (rx_strobe && !rx_dc) begin
        cmd_valid_q <= 1'b1;
        cmd_byte_q  <= rx_byte;
        pcnt_q      <= '0;
        case (rx_byte)
          CMD_CASET: state_q <= ST_CASET_P;
          CMD_RASET: state_q <= ST_RASET_P;
          CMD_RAMWR: begin
            state_q    <= ST_RAMWR;
            cx_q       <= xs_q;
            cy_q       <= ys_q;
            phase_lo_q <= 1'b0;
          end
          default:   state_q <= ST_SKIP;
        endcase
      end else if (rx_strobe) begin
        case (state_q)
          ST_CASET_P, ST_RASET_P: begin
            if (pcnt_q == 2'd3) begin
              if (state_q == ST_CASET_P) begin
                if (x_ok) begin
                  xs_q <= p_start[XW-1:0];
                  xe_q <= p_end[XW-1:0];
                end else err_q <= 1'b1;
              end else begin
                if (y_ok) begin
                  ys_q <= p_start[YW-1:0];
                  ye_q <= p_end[YW-1:0];
                end else err_q <= 1'b1;
              end
              state_q <= ST_SKIP;
            end else begin
              par_q  <= {par_q[15:0], rx_byte};
              pcnt_q <= pcnt_q + 2'd1;
            end
          end
          ST_RAMWR: begin
            if (!phase_lo_q) begin
              hi_q       <= rx_byte;
              phase_lo_q <= 1'b1;
            end else begin
              phase_lo_q   <= 1'b0;
              pix_valid_q  <= 1'b1;
              pix_data_q   <= {hi_q, rx_byte};
              pix_x_q      <= cx_q;
              pix_y_q      <= cy_q;
              frame_done_q <= (cx_q == xe_q) && (cy_q == ye_q);
              if (cx_q == xe_q) begin
                cx_q <= xs_q;
                cy_q <= (cy_q == ye_q) ? ys_q : cy_q + YW'(1);
              end else cx_q <= cx_q + XW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_byte   = cmd_byte_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_x      = pix_x_q;
  assign bus.pix_y      = pix_y_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Bench for lcd_spi_rx: directed scenarios plus random windows and pixel
// streams, scored against a byte-level model of the panel command set.
module tb_lcd_spi_rx;

  localparam int HR = 240;
  localparam int VR = 240;
  localparam int M_IDLE = 0, M_CAS = 1, M_RAS = 2, M_RAM = 3, M_SKIP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_spi_rx_if #(.H_RES(HR), .V_RES(VR)) bus ();

  lcd_spi_rx #(.H_RES(HR), .V_RES(VR), .SYNC_STAGES(2)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // observed stream
  logic [63:0] obs_cmd[$];
  logic [63:0] obs_pix[$];
  int obs_err = 0;
  int stray_fd = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.cmd_valid) obs_cmd.push_back(64'(bus.cmd_byte));
      if (bus.pix_valid) obs_pix.push_back(64'({bus.frame_done, bus.pix_y, bus.pix_x, bus.pix_data}));
      if (bus.err) obs_err++;
      if (bus.frame_done && !bus.pix_valid) stray_fd++;
    end
  end

  // reference model
  logic [63:0] exp_cmd[$];
  logic [63:0] exp_pix[$];
  int exp_err = 0;
  int m_st = M_IDLE;
  int mxs = 0, mxe = HR - 1, mys = 0, mye = VR - 1;
  int cx = 0, cy = 0, phase = 0, hi = 0, np = 0;
  int prm[4];

  task automatic model_byte(input bit dc, input int b);
    int s, e, fd;
    if (!dc) begin
      exp_cmd.push_back(64'(b));
      np = 0;
      if (b == 'h2A) m_st = M_CAS;
      else if (b == 'h2B) m_st = M_RAS;
      else if (b == 'h2C) begin m_st = M_RAM; cx = mxs; cy = mys; phase = 0; end
      else m_st = M_SKIP;
    end else if (m_st == M_CAS || m_st == M_RAS) begin
      prm[np] = b;
      np++;
      if (np == 4) begin
        s = prm[0] * 256 + prm[1];
        e = prm[2] * 256 + prm[3];
        if (s <= e && e < ((m_st == M_CAS) ? HR : VR)) begin
          if (m_st == M_CAS) begin mxs = s; mxe = e; end
          else begin mys = s; mye = e; end
        end else exp_err++;
        m_st = M_SKIP;
      end
    end else if (m_st == M_RAM) begin
      if (phase == 0) begin hi = b; phase = 1; end
      else begin
        phase = 0;
        fd = (cx == mxe && cy == mye) ? 1 : 0;
        exp_pix.push_back(64'({1'(fd), 8'(cy), 8'(cx), 8'(hi), 8'(b)}));
        if (cx == mxe) begin
          cx = mxs;
          cy = (cy == mye) ? mys : cy + 1;
        end else cx++;
      end
    end
  endtask

  // SPI driver, SCLK = clk/8
  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input bit dc, input logic [7:0] b, input int nbits);
    if (bus.spi_cs) begin bus.spi_cs = 1'b0; wclk(3); end
    bus.spi_dc = dc;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = b[7-i];
      wclk(4);
      bus.spi_sclk = 1'b1;
      wclk(4);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic send(input bit dc, input int b);
    spi_bits(dc, 8'(b), 8);
    model_byte(dc, b);
  endtask

  task automatic cs_gap();
    wclk(2);
    bus.spi_cs = 1'b1;
    wclk(6);
  endtask

  task automatic partial(input int nbits);
    spi_bits(1'b0, 8'hA5, nbits);
    bus.spi_cs = 1'b1;
    wclk(6);
    exp_err++;
  endtask

  task automatic send_win(input int cmd, input int s, input int e);
    send(0, cmd);
    send(1, s >> 8); send(1, s & 255);
    send(1, e >> 8); send(1, e & 255);
  endtask

  task automatic send_pix(input int d);
    send(1, d >> 8);
    send(1, d & 255);
  endtask

  task automatic score(input string tag);
    wclk(30);
    chk({tag, ".ncmd"}, 64'(obs_cmd.size()), 64'(exp_cmd.size()));
    chk({tag, ".npix"}, 64'(obs_pix.size()), 64'(exp_pix.size()));
    while (obs_cmd.size() > 0 && exp_cmd.size() > 0)
      chk({tag, ".cmd"}, obs_cmd.pop_front(), exp_cmd.pop_front());
    while (obs_pix.size() > 0 && exp_pix.size() > 0)
      chk({tag, ".pix{fd,y,x,d}"}, obs_pix.pop_front(), exp_pix.pop_front());
    obs_cmd.delete(); exp_cmd.delete();
    obs_pix.delete(); exp_pix.delete();
    chk({tag, ".err"}, 64'(obs_err), 64'(exp_err));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".outs"}, 64'({bus.cmd_valid, bus.cmd_byte, bus.pix_valid, bus.pix_x,
                             bus.pix_y, bus.pix_data, bus.frame_done, bus.err}), 64'd0);
  endtask

  initial begin
    int xs, xe, ys, ye, n;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_cs   = 1'b1;
    bus.spi_dc   = 1'b0;
    wclk(5);
    chk_idle_outputs("in_reset");
    rst_n = 1'b1;
    wclk(10);
    chk_idle_outputs("after_reset");

    // single red pixel at origin
    send(0, 'h2C); send_pix('hF800);
    score("ramwr1");
    // unknown command, trailing data ignored
    send(0, 'h11); send(1, 'h55);
    score("cmd11");
    // start > end rejected, window stays full-panel
    send_win('h2A, 10, 5);
    send(0, 'h2C); send_pix('h1234);
    score("bad_caset");
    // CS abort mid-byte, then a clean RAMWR
    partial(5);
    send(0, 'h2C);
    score("abort");
    // small window with wrap, CS toggles inside RAMWR
    send_win('h2A, 2, 4);
    send_win('h2B, 1, 2);
    send(0, 'h2C);
    for (int i = 0; i < 9; i++) begin
      send_pix(16'h0100 * i + 16'h00A0);
      if (i == 3) cs_gap();
    end
    score("window");
    // truncated CASET leaves window alone
    send(0, 'h2A); send(1, 0); send(1, 7);
    send(0, 'h2C); send_pix('hBEEF);
    score("trunc");
    // end coordinate at the panel edge and just past it
    send_win('h2A, 238, 239);
    send_win('h2B, 0, 240);
    send(0, 'h2C);
    for (int i = 0; i < 3; i++) send_pix(i);
    score("edge");

    for (int it = 0; it < 8; it++) begin
      xs = $urandom_range(0, 6); xe = xs + $urandom_range(0, 3);
      ys = $urandom_range(0, 6); ye = ys + $urandom_range(0, 2);
      if ($urandom_range(0, 3) == 0) xe = HR + $urandom_range(0, 20);
      if ($urandom_range(0, 3) == 0) begin n = ys; ys = ye + 1; ye = n; end
      send_win('h2A, xs, xe);
      if ($urandom_range(0, 1) == 1) send(1, $urandom_range(0, 255));
      send_win('h2B, ys, ye);
      if ($urandom_range(0, 2) == 0) begin
        send(0, $urandom_range(0, 255));
        send(1, $urandom_range(0, 255));
      end
      if ($urandom_range(0, 3) == 0) partial($urandom_range(1, 7));
      send(0, 'h2C);
      n = $urandom_range(1, 12);
      for (int p = 0; p < n; p++) begin
        send_pix($urandom_range(0, 65535));
        if ($urandom_range(0, 3) == 0) cs_gap();
      end
      score($sformatf("rnd%0d", it));
    end

    chk("stray_frame_done", 64'(stray_fd), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
